// File: rtl/rv_isa_pkg.sv
// rv_isa_pkg: RV32I opcode and funct3 codes, the jump operation-select codes,
// the decode FSM state type and the packed issue bundle for rv_decode_issue.
package rv_isa_pkg;

  localparam int RV_XLEN = 32;

  // Major opcodes, compared against instr[6:2]
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  // funct3 values where instr[30] selects the alternate operation
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;

  // Operation select presented for the two jump forms
  localparam logic [2:0] FCS_JAL  = 3'b010;
  localparam logic [2:0] FCS_JALR = 3'b011;

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_BR_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic               lup;
    logic               ub;
    logic               cb;
    logic               mem;
    logic               alu_imm;
    logic               alu_reg;
    logic               iop;
    logic               fc;
    logic [2:0]         fcs;
    logic [RV_XLEN-1:0] port1;
    logic [RV_XLEN-1:0] port2;
    logic [RV_XLEN-1:0] imm;
    logic [RV_XLEN-1:0] pc;
    logic [4:0]         rd;
  } issue_bundle_t;

endpackage

// File: rtl/rv_imm_gen.sv
// rv_imm_gen: combinational RV32I immediate extraction selected by opcode.
// Ports:
//   instr_i  in  32  instruction word
//   imm_o    out 32  immediate (0 for formats without one)
module rv_imm_gen
  import rv_isa_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [31:0] imm_o
);

  // The two low opcode bits carry no format information in RV32I
  logic unused_opc_lsbs;
  assign unused_opc_lsbs = ^instr_i[1:0];

  always_comb begin
    imm_o = '0;
    case (instr_i[6:2])
      OPC_OP_IMM, OPC_JALR, OPC_LOAD:
        imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      OPC_STORE:
        imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      OPC_BRANCH:
        imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                 instr_i[11:8], 1'b0};
      OPC_JAL:
        imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                 instr_i[30:21], 1'b0};
      OPC_AUIPC:
        imm_o = {instr_i[31:12], 12'b0};
      // LUI carries the raw upper field right-justified; execute does the shift
      OPC_LUI:
        imm_o = {12'b0, instr_i[31:12]};
      default:
        imm_o = '0;
    endcase
  end

endmodule

// File: rtl/rv_decode_issue.sv
// rv_decode_issue: RV32I decode/issue stage feeding the execute ALU.
// Decodes one instruction per handshake into block-select flags and operands,
// keeps a register file with a busy-bit scoreboard for RAW stalls, and halts
// issue after any branch/jump until execute reports resolution.
// Ports:
//   clk, rst                      clock, async active-high reset
//   instr_valid/instr/instr_pc    fetch side; instr_ready accepts
//   issue_valid/issue_ready       execute-side handshake
//   LUP..FC, finite_control_sig   registered control flags
//   port1_reg, port2_reg,
//   port2_imm, program_counter,
//   rd_out                        registered operands
//   wb_en/wb_addr/wb_data         register write-back
//   br_done                       outstanding branch/jump resolved
//   illegal_instr                 pulse when an unsupported opcode is dropped
module rv_decode_issue
  import rv_isa_pkg::*;
#(
  parameter int XLEN = RV_XLEN,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] instr_pc,
  output logic            instr_ready,
  output logic            issue_valid,
  input  logic            issue_ready,
  output logic            LUP,
  output logic            UB,
  output logic            CB,
  output logic            MEM,
  output logic            ALU_IMM,
  output logic            ALU_REG,
  output logic            IOP,
  output logic            FC,
  output logic [2:0]      finite_control_sig,
  output logic [XLEN-1:0] port1_reg,
  output logic [XLEN-1:0] port2_reg,
  output logic [XLEN-1:0] port2_imm,
  output logic [XLEN-1:0] program_counter,
  output logic [4:0]      rd_out,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            br_done,
  output logic            illegal_instr
);

  logic [4:0] opc, rd_f, rs1_f, rs2_f;
  logic [2:0] f3;
  assign opc   = instr[6:2];
  assign f3    = instr[14:12];
  assign rd_f  = instr[11:7];
  assign rs1_f = instr[19:15];
  assign rs2_f = instr[24:20];

  logic [XLEN-1:0] imm;
  rv_imm_gen u_imm_gen (
    .instr_i (instr),
    .imm_o   (imm)
  );

  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  state_e          state_q, state_d;
  issue_bundle_t   bundle_q, bundle_d, dec;
  logic            issue_valid_q, issue_valid_d;
  logic            illegal_q, illegal_d;

  // Register read with same-cycle write-back bypass; x0 always reads zero
  logic            wb_live, wb_hit1, wb_hit2;
  logic [XLEN-1:0] rs1_val, rs2_val;
  assign wb_live = wb_en && (wb_addr != 5'd0);
  assign wb_hit1 = wb_live && (wb_addr == rs1_f);
  assign wb_hit2 = wb_live && (wb_addr == rs2_f);

  always_comb begin
    rs1_val = wb_hit1 ? wb_data : regs_q[rs1_f];
    rs2_val = wb_hit2 ? wb_data : regs_q[rs2_f];
    if (rs1_f == 5'd0) rs1_val = '0;
    if (rs2_f == 5'd0) rs2_val = '0;
  end

  logic legal, use_rs1, use_rs2, writes_rd, is_branch;

  always_comb begin
    dec       = '0;
    legal     = 1'b1;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    writes_rd = 1'b0;
    is_branch = 1'b0;
    dec.fcs   = f3;
    dec.port1 = rs1_val;
    dec.port2 = rs2_val;
    dec.imm   = imm;
    dec.pc    = instr_pc;
    case (opc)
      OPC_OP_IMM: begin
        dec.alu_imm = 1'b1;
        dec.fc      = 1'b1;
        dec.iop     = (f3 == F3_SRL_SRA) && instr[30];
        use_rs1     = 1'b1;
        writes_rd   = 1'b1;
      end
      OPC_OP: begin
        dec.alu_reg = 1'b1;
        dec.fc      = 1'b1;
        dec.iop     = ((f3 == F3_ADD_SUB) || (f3 == F3_SRL_SRA)) && instr[30];
        use_rs1     = 1'b1;
        use_rs2     = 1'b1;
        writes_rd   = 1'b1;
      end
      OPC_BRANCH: begin
        dec.cb    = 1'b1;
        dec.fc    = 1'b1;
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        is_branch = 1'b1;
      end
      OPC_JAL: begin
        dec.ub    = 1'b1;
        dec.fc    = 1'b1;
        dec.fcs   = FCS_JAL;
        writes_rd = 1'b1;
        is_branch = 1'b1;
      end
      OPC_JALR: begin
        // execute takes the jump base from port2 for JALR
        dec.ub    = 1'b1;
        dec.fc    = 1'b1;
        dec.fcs   = FCS_JALR;
        dec.port2 = rs1_val;
        use_rs1   = 1'b1;
        writes_rd = 1'b1;
        is_branch = 1'b1;
      end
      OPC_LUI: begin
        dec.lup   = 1'b1;
        dec.iop   = 1'b1;
        dec.fcs   = 3'b000;
        writes_rd = 1'b1;
      end
      OPC_AUIPC: begin
        dec.lup   = 1'b1;
        dec.fcs   = 3'b000;
        writes_rd = 1'b1;
      end
      OPC_LOAD: begin
        dec.mem   = 1'b1;
        use_rs1   = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_STORE: begin
        dec.mem = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    dec.rd = writes_rd ? rd_f : 5'd0;
  end

  // A busy source stops issue unless its producer is writing back right now
  logic raw_stall, accept;
  assign raw_stall = (use_rs1 && (rs1_f != 5'd0) && busy_q[rs1_f] && !wb_hit1) ||
                     (use_rs2 && (rs2_f != 5'd0) && busy_q[rs2_f] && !wb_hit2);

  assign instr_ready = !rst && (state_q == ST_RUN) && !raw_stall &&
                       (!issue_valid_q || issue_ready);
  assign accept      = instr_valid && instr_ready;

  always_comb begin
    bundle_d      = bundle_q;
    issue_valid_d = issue_valid_q;
    illegal_d     = 1'b0;
    state_d       = state_q;
    busy_d        = busy_q;
    if (issue_valid_q && issue_ready) issue_valid_d = 1'b0;
    if (accept) begin
      if (legal) begin
        bundle_d      = dec;
        issue_valid_d = 1'b1;
      end else begin
        illegal_d = 1'b1;
      end
    end
    // br_done is only meaningful once the wait has begun
    if ((state_q == ST_BR_WAIT) && br_done) state_d = ST_RUN;
    if (accept && legal && is_branch) state_d = ST_BR_WAIT;
    // clear before set so a same-register collision leaves the bit set
    if (wb_live) busy_d[wb_addr] = 1'b0;
    if (accept && legal && writes_rd && (rd_f != 5'd0)) busy_d[rd_f] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_RUN;
      bundle_q      <= '0;
      issue_valid_q <= 1'b0;
      illegal_q     <= 1'b0;
      busy_q        <= '0;
    end else begin
      state_q       <= state_d;
      bundle_q      <= bundle_d;
      issue_valid_q <= issue_valid_d;
      illegal_q     <= illegal_d;
      busy_q        <= busy_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wb_live) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  assign issue_valid        = issue_valid_q;
  assign illegal_instr      = illegal_q;
  assign LUP                = bundle_q.lup;
  assign UB                 = bundle_q.ub;
  assign CB                 = bundle_q.cb;
  assign MEM                = bundle_q.mem;
  assign ALU_IMM            = bundle_q.alu_imm;
  assign ALU_REG            = bundle_q.alu_reg;
  assign IOP                = bundle_q.iop;
  assign FC                 = bundle_q.fc;
  assign finite_control_sig = bundle_q.fcs;
  assign port1_reg          = bundle_q.port1;
  assign port2_reg          = bundle_q.port2;
  assign port2_imm          = bundle_q.imm;
  assign program_counter    = bundle_q.pc;
  assign rd_out             = bundle_q.rd;

endmodule

// File: tb/tb_rv_decode_issue.sv
module tb_rv_decode_issue;

  logic        clk, rst;
  logic        instr_valid, instr_ready, issue_valid, issue_ready;
  logic [31:0] instr, instr_pc;
  logic        LUP, UB, CB, MEM, ALU_IMM, ALU_REG, IOP, FC;
  logic [2:0]  finite_control_sig;
  logic [31:0] port1_reg, port2_reg, port2_imm, program_counter;
  logic [4:0]  rd_out;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        br_done, illegal_instr;

  rv_decode_issue dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .LUP(LUP), .UB(UB), .CB(CB), .MEM(MEM), .ALU_IMM(ALU_IMM), .ALU_REG(ALU_REG),
    .IOP(IOP), .FC(FC), .finite_control_sig(finite_control_sig),
    .port1_reg(port1_reg), .port2_reg(port2_reg), .port2_imm(port2_imm),
    .program_counter(program_counter), .rd_out(rd_out),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .br_done(br_done), .illegal_instr(illegal_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic lup, ub, cb, mem, alu_imm, alu_reg, iop, fc;
    logic [2:0]  fcs;
    logic [31:0] p1, p2, imm, pc;
    logic [4:0]  rd;
  } bnd_t;

  typedef struct packed {
    bnd_t b;
    logic legal, u1, u2, wr, br;
  } dec_t;

  bnd_t act;
  assign act = {LUP, UB, CB, MEM, ALU_IMM, ALU_REG, IOP, FC, finite_control_sig,
                port1_reg, port2_reg, port2_imm, program_counter, rd_out};

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_regs [32];
  bit          m_busy [32];
  bit          m_wait, m_valid, m_ill;
  bnd_t        m_bnd;

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_wait = 0; m_valid = 0; m_ill = 0; m_bnd = '0;
  endtask

  function automatic logic [31:0] sx(input logic [31:0] v, input int nb);
    return v[nb-1] ? v - (32'd1 << nb) : v;
  endfunction

  function automatic logic [31:0] m_rdv(input logic [4:0] r);
    if (r == 0) return '0;
    if (wb_en && wb_addr == r) return wb_data;
    return m_regs[r];
  endfunction

  function automatic logic m_stall(input logic [4:0] r);
    return (r != 0) && m_busy[r] && !(wb_en && wb_addr == r);
  endfunction

  function automatic dec_t m_decode(input logic [31:0] ins, input logic [31:0] pc);
    dec_t d;
    logic [2:0] f3;
    f3 = ins[14:12];
    d = '0;
    d.legal = 1;
    d.b.pc = pc;
    d.b.p1 = m_rdv(ins[19:15]);
    d.b.p2 = m_rdv(ins[24:20]);
    d.b.fcs = f3;
    case (ins[6:0])
      7'h13: begin
        d.b.alu_imm = 1; d.b.fc = 1; d.b.iop = (f3 == 3'd5) ? ins[30] : 1'b0;
        d.b.imm = sx(ins >> 20, 12); d.u1 = 1; d.wr = 1;
      end
      7'h33: begin
        d.b.alu_reg = 1; d.b.fc = 1;
        d.b.iop = (f3 == 3'd0 || f3 == 3'd5) ? ins[30] : 1'b0;
        d.u1 = 1; d.u2 = 1; d.wr = 1;
      end
      7'h63: begin
        d.b.cb = 1; d.b.fc = 1; d.u1 = 1; d.u2 = 1; d.br = 1;
        d.b.imm = sx(((ins >> 8) & 32'hF) * 32'd2 + ((ins >> 25) & 32'h3F) * 32'd32 +
                     ((ins >> 7) & 32'h1) * 32'd2048 + ((ins >> 31) & 32'h1) * 32'd4096, 13);
      end
      7'h6F: begin
        d.b.ub = 1; d.b.fc = 1; d.b.fcs = 3'd2; d.wr = 1; d.br = 1;
        d.b.imm = sx(((ins >> 21) & 32'h3FF) * 32'd2 + ((ins >> 20) & 32'h1) * 32'd2048 +
                     ((ins >> 12) & 32'hFF) * 32'd4096 + ((ins >> 31) & 32'h1) * 32'h100000, 21);
      end
      7'h67: begin
        d.b.ub = 1; d.b.fc = 1; d.b.fcs = 3'd3; d.wr = 1; d.br = 1; d.u1 = 1;
        d.b.p2 = d.b.p1; d.b.imm = sx(ins >> 20, 12);
      end
      7'h37: begin
        d.b.lup = 1; d.b.iop = 1; d.b.fcs = 0; d.wr = 1; d.b.imm = ins >> 12;
      end
      7'h17: begin
        d.b.lup = 1; d.b.fcs = 0; d.wr = 1; d.b.imm = ins & 32'hFFFFF000;
      end
      7'h03: begin
        d.b.mem = 1; d.u1 = 1; d.wr = 1; d.b.imm = sx(ins >> 20, 12);
      end
      7'h23: begin
        d.b.mem = 1; d.u1 = 1; d.u2 = 1;
        d.b.imm = sx(((ins >> 25) << 5) | ((ins >> 7) & 32'h1F), 12);
      end
      default: d.legal = 0;
    endcase
    d.b.rd = d.wr ? ins[11:7] : 5'd0;
    return d;
  endfunction

  function automatic logic m_ready();
    dec_t d;
    if (rst || m_wait) return 1'b0;
    if (m_valid && !issue_ready) return 1'b0;
    d = m_decode(instr, instr_pc);
    if (d.u1 && m_stall(instr[19:15])) return 1'b0;
    if (d.u2 && m_stall(instr[24:20])) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ir, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic bd);
    @(negedge clk);
    instr_valid = v; instr = ins; instr_pc = pc; issue_ready = ir;
    wb_en = we; wb_addr = wa; wb_data = wd; br_done = bd;
    #1;
  endtask

  // Advance one clock edge, stepping the reference model with the inputs
  // that were stable before the edge.
  task automatic tick();
    logic rdy, acc;
    dec_t d;
    rdy = m_ready();
    d = m_decode(instr, instr_pc);
    @(posedge clk);
    if (rst) begin
      m_reset();
    end else begin
      acc = instr_valid && rdy;
      if (acc && d.legal) begin
        m_bnd = d.b; m_valid = 1; m_ill = 0;
      end else if (acc) begin
        m_valid = 0; m_ill = 1;
      end else begin
        m_ill = 0;
        if (issue_ready) m_valid = 0;
      end
      if (wb_en && wb_addr != 0) begin
        m_regs[wb_addr] = wb_data;
        m_busy[wb_addr] = 0;
      end
      if (acc && d.legal && d.wr && d.b.rd != 0) m_busy[d.b.rd] = 1;
      if (m_wait && br_done) m_wait = 0;
      if (acc && d.legal && d.br) m_wait = 1;
    end
    #1;
  endtask

  localparam logic [31:0] NOP = 32'h0000_0013;

  task automatic test_reset();
    rst = 1;
    m_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); @(posedge clk); #1;
    n_checks++;
    if ({instr_ready, issue_valid, illegal_instr, act} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b ill=%b bundle=%h, want all zero",
               instr_ready, issue_valid, illegal_instr, act);
    end
    @(negedge clk); rst = 0; #1;
    n_checks++;
    if (instr_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready: got %b want 1", instr_ready);
    end
  endtask

  task automatic test_addi();
    drive(1, 32'hFFB0_0093, 32'h0, 1, 0, 0, 0, 0);
    n_checks++;
    if (instr_ready !== 1'b1) begin
      n_fail++; $display("FAIL addi_ready: got %b want 1", instr_ready);
    end
    tick();
    n_checks++;
    if ({issue_valid, ALU_IMM, IOP, finite_control_sig, port2_imm, rd_out} !==
        {1'b1, 1'b1, 1'b0, 3'b000, 32'hFFFF_FFFB, 5'd1}) begin
      n_fail++;
      $display("FAIL addi_decode: got vld=%b alu_imm=%b iop=%b fcs=%b imm=%h rd=%0d, want 1 1 0 000 fffffffb 1",
               issue_valid, ALU_IMM, IOP, finite_control_sig, port2_imm, rd_out);
    end
  endtask

  task automatic test_sub_bypass();
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'h4020_81B3, 32'h4, 1, 0, 0, 0, 0);
      n_checks++;
      if (instr_ready !== 1'b0) begin
        n_fail++; $display("FAIL sub_raw_stall: got ready %b want 0", instr_ready);
      end
      tick();
    end
    drive(1, 32'h4020_81B3, 32'h4, 1, 1, 5'd1, 32'h1234_5678, 0);
    n_checks++;
    if (instr_ready !== 1'b1) begin
      n_fail++; $display("FAIL sub_wb_ready: got %b want 1", instr_ready);
    end
    tick();
    n_checks++;
    if ({issue_valid, ALU_REG, IOP, finite_control_sig, port1_reg, rd_out} !==
        {1'b1, 1'b1, 1'b1, 3'b000, 32'h1234_5678, 5'd3}) begin
      n_fail++;
      $display("FAIL sub_bypass: got vld=%b alu_reg=%b iop=%b fcs=%b p1=%h rd=%0d, want 1 1 1 000 12345678 3",
               issue_valid, ALU_REG, IOP, finite_control_sig, port1_reg, rd_out);
    end
  endtask

  task automatic test_branch();
    // br_done during the accepting cycle must not end the wait
    drive(1, 32'h0000_0463, 32'h100, 1, 0, 0, 0, 1);
    tick();
    n_checks++;
    if ({issue_valid, CB, FC, port2_imm, program_counter, rd_out} !==
        {1'b1, 1'b1, 1'b1, 32'd8, 32'h100, 5'd0}) begin
      n_fail++;
      $display("FAIL beq_decode: got vld=%b cb=%b fc=%b imm=%h pc=%h rd=%0d, want 1 1 1 8 100 0",
               issue_valid, CB, FC, port2_imm, program_counter, rd_out);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1, NOP, 32'h104, 1, 0, 0, 0, (i == 3));
      n_checks++;
      if (instr_ready !== 1'b0) begin
        n_fail++; $display("FAIL br_wait_ready: cycle %0d got %b want 0", i, instr_ready);
      end
      tick();
    end
    drive(1, NOP, 32'h104, 1, 0, 0, 0, 0);
    n_checks++;
    if (instr_ready !== 1'b1) begin
      n_fail++; $display("FAIL br_resume_ready: got %b want 1", instr_ready);
    end
    tick();
    n_checks++;
    if ({issue_valid, ALU_IMM, CB} !== 3'b110) begin
      n_fail++; $display("FAIL br_resume_issue: got vld/alu_imm/cb=%b want 110",
                         {issue_valid, ALU_IMM, CB});
    end
  endtask

  task automatic test_lui_auipc();
    drive(1, 32'h1234_52B7, 32'h200, 1, 0, 0, 0, 0);
    tick();
    n_checks++;
    if ({LUP, IOP, FC, port2_imm, rd_out} !== {1'b1, 1'b1, 1'b0, 32'h0001_2345, 5'd5}) begin
      n_fail++;
      $display("FAIL lui_decode: got lup=%b iop=%b fc=%b imm=%h rd=%0d, want 1 1 0 00012345 5",
               LUP, IOP, FC, port2_imm, rd_out);
    end
    drive(1, 32'h1234_5297, 32'h204, 1, 0, 0, 0, 0);
    tick();
    n_checks++;
    if ({LUP, IOP, port2_imm, program_counter} !== {1'b1, 1'b0, 32'h1234_5000, 32'h204}) begin
      n_fail++;
      $display("FAIL auipc_decode: got lup=%b iop=%b imm=%h pc=%h, want 1 0 12345000 204",
               LUP, IOP, port2_imm, program_counter);
    end
  endtask

  task automatic test_backpressure_illegal();
    bnd_t held;
    drive(1, NOP, 32'h300, 1, 0, 0, 0, 0);
    tick();
    held = act;
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h0070_0113, 32'h304, 0, 0, 0, 0, 0);
      n_checks++;
      if (instr_ready !== 1'b0) begin
        n_fail++; $display("FAIL stall_ready: cycle %0d got %b want 0", i, instr_ready);
      end
      tick();
      n_checks++;
      if (issue_valid !== 1'b1 || act !== held) begin
        n_fail++; $display("FAIL stall_hold: vld=%b bundle=%h want 1 %h", issue_valid, act, held);
      end
    end
    drive(1, 32'h0000_007F, 32'h308, 1, 0, 0, 0, 0);
    tick();
    n_checks++;
    if ({illegal_instr, issue_valid} !== 2'b10) begin
      n_fail++; $display("FAIL illegal_pulse: got ill/vld=%b want 10", {illegal_instr, issue_valid});
    end
    drive(0, NOP, 32'h30C, 1, 0, 0, 0, 0);
    tick();
    n_checks++;
    if ({illegal_instr, issue_valid} !== 2'b00) begin
      n_fail++; $display("FAIL illegal_once: got ill/vld=%b want 00", {illegal_instr, issue_valid});
    end
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    logic [6:0]  op;
    w = $urandom;
    case ($urandom_range(0, 19))
      0, 1, 2:   op = 7'h13;
      3, 4, 5:   op = 7'h33;
      6, 7:      op = 7'h63;
      8:         op = 7'h6F;
      9:         op = 7'h67;
      10:        op = 7'h37;
      11:        op = 7'h17;
      12, 13:    op = 7'h03;
      14, 15:    op = 7'h23;
      16:        op = 7'h7F;
      17:        op = 7'h0B;
      default:   op = 7'h13;
    endcase
    w[6:0]   = op;
    w[11:7]  = 5'($urandom_range(0, 7));
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    return w;
  endfunction

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 3) != 0, gen_instr(), $urandom & 32'hFFFF_FFFC,
            $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 3) == 0);
      n_checks++;
      if (instr_ready !== m_ready()) begin
        n_fail++;
        $display("FAIL rand_ready: cycle %0d instr=%h got %b want %b", c, instr, instr_ready, m_ready());
      end
      tick();
      n_checks++;
      if (issue_valid !== m_valid || illegal_instr !== m_ill) begin
        n_fail++;
        $display("FAIL rand_valid: cycle %0d got vld=%b ill=%b want vld=%b ill=%b",
                 c, issue_valid, illegal_instr, m_valid, m_ill);
      end
      if (m_valid) begin
        n_checks++;
        if (act !== m_bnd) begin
          n_fail++;
          $display("FAIL rand_bundle: cycle %0d got %h want %h", c, act, m_bnd);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    // leave any branch wait, load x1 with data, then get busy + BR_WAIT
    drive(0, NOP, 0, 1, 1, 5'd1, 32'hDEAD_BEEF, 1);
    tick();
    drive(1, 32'h0010_0313, 32'h400, 1, 0, 0, 0, 0);
    n_checks++;
    if (instr_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_addi_ready: got %b want 1", instr_ready);
    end
    tick();
    drive(1, 32'h0000_03EF, 32'h404, 1, 0, 0, 0, 0);
    tick();
    drive(1, NOP, 32'h408, 1, 0, 0, 0, 0);
    n_checks++;
    if (instr_ready !== 1'b0 || UB !== 1'b1) begin
      n_fail++; $display("FAIL mid_br_wait: got ready=%b ub=%b want 0 1", instr_ready, UB);
    end
    #2 rst = 1;
    #1;
    n_checks++;
    if ({instr_ready, issue_valid, illegal_instr, act} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_async: got rdy=%b vld=%b ill=%b bundle=%h, want all zero",
               instr_ready, issue_valid, illegal_instr, act);
    end
    m_reset();
    @(posedge clk);
    @(negedge clk); rst = 0;
    // ADD x9,x1,x6: x6 was busy and x1 held data before reset
    drive(1, 32'h0060_84B3, 32'h500, 1, 0, 0, 0, 0);
    n_checks++;
    if (instr_ready !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_ready: got %b want 1", instr_ready);
    end
    tick();
    n_checks++;
    if ({issue_valid, ALU_REG, port1_reg, port2_reg, rd_out} !==
        {1'b1, 1'b1, 32'h0, 32'h0, 5'd9}) begin
      n_fail++;
      $display("FAIL post_reset_regs: got vld=%b alu_reg=%b p1=%h p2=%h rd=%0d, want 1 1 0 0 9",
               issue_valid, ALU_REG, port1_reg, port2_reg, rd_out);
    end
    n_checks++;
    if (act !== m_bnd) begin
      n_fail++; $display("FAIL post_reset_bundle: got %h want %h", act, m_bnd);
    end
  endtask

  initial begin
    rst = 1;
    instr_valid = 0; instr = 0; instr_pc = 0; issue_ready = 0;
    wb_en = 0; wb_addr = 0; wb_data = 0; br_done = 0;
    test_reset();
    test_addi();
    test_sub_bypass();
    test_branch();
    test_lui_auipc();
    test_backpressure_illegal();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rv_decode_issue.md
Name: rv_decode_issue

Overview:
- Decode/issue stage that drives the execute ALU's control interface.
- Accepts one RV32I instruction word plus PC per handshake and decodes it into the ALU block-select flags (LUP, UB, CB, MEM, ALU_IMM, ALU_REG), the IOP/FC flags, finite_control_sig and operands.
- Holds an internal register file, written back from the ALU result, with a busy-bit scoreboard for RAW stalls.
- Stalls after every branch or jump until execute signals resolution.

Parameters:
- XLEN, 32, datapath width.
- NREG, 32, architectural register count; x0 is hardwired to zero.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_valid  in  1  fetch presents an instruction.
- instr  in  32  RV32I instruction word.
- instr_pc  in  32  PC of instr.
- instr_ready  out  1  decode accepts this cycle.
- issue_valid  out  1  output bundle valid.
- issue_ready  in  1  execute accepts the bundle.
- LUP, UB, CB, MEM, ALU_IMM, ALU_REG, IOP, FC  out  1 each  registered control flags, one-hot across the six block flags.
- finite_control_sig  out  3  operation select.
- port1_reg, port2_reg, port2_imm, program_counter  out  32 each  operands.
- rd_out  out  5  destination register, 0 if none.
- wb_en  in  1  write-back strobe.
- wb_addr  in  5  write-back register.
- wb_data  in  32  write-back data.
- br_done  in  1  execute has resolved the outstanding branch or jump.
- illegal_instr  out  1  one-cycle pulse when an unsupported opcode is dropped.

Behaviour:
- Reset (async): every output 0, including issue_valid and illegal_instr. Regfile and busy bits cleared. State = RUN. Reset mid-operation drops any in-flight bundle and any outstanding branch wait.
- Accept condition: instr_valid && instr_ready. instr_ready = (state==RUN) && !raw_stall && (!issue_valid || issue_ready).
- Latency: bundle is registered, so issue_valid rises the cycle after acceptance. Bundle and issue_valid hold stable while issue_valid && !issue_ready. issue_valid drops after a transfer if no new accept occurs.
- Decode by opcode[6:2]:
  - 00100 (OP-IMM) -> ALU_IMM.
  - 01100 (OP) -> ALU_REG.
  - 11000 -> CB.
  - 11011 (JAL) -> UB, fcs=010.
  - 11001 (JALR) -> UB, fcs=011.
  - 01101 (LUI) -> LUP, IOP=1.
  - 00101 (AUIPC) -> LUP, IOP=0.
  - 00000 / 01000 (load/store) -> MEM.
  - Anything else -> not issued, illegal_instr pulses, instruction consumed.
- finite_control_sig = funct3 for ALU_IMM, ALU_REG, CB and MEM.
- IOP = instr[30] for ALU_REG funct3 000/101 and for ALU_IMM funct3 101; 0 otherwise except LUI.
- FC = 1 for ALU_IMM, ALU_REG, CB, UB; 0 for LUP and MEM.
- Immediates, all sign-extended unless stated:
  - I-type for OP-IMM, JALR and loads.
  - S-type for stores.
  - B-type for CB.
  - J-type for JAL.
  - AUIPC: {instr[31:12], 12'b0}.
  - LUI: instr[31:12] zero-extended and right-justified.
- Operands:
  - port1_reg = rs1 value.
  - port2_reg = rs2 value, except JALR, where port2_reg = rs1 value.
  - program_counter = instr_pc.
- Register read: x0 reads 0. A write-back to the same register in the same cycle bypasses wb_data into the read.
- Write-back: wb_en writes wb_data to wb_addr and clears busy[wb_addr]. wb_addr==0 is ignored.
- Scoreboard:
  - An issued instruction with rd!=0 of class ALU_IMM, ALU_REG, LUP, UB or load sets busy[rd].
  - If set and clear hit the same register in the same cycle, set wins.
  - raw_stall = a used source (rs1/rs2 as applicable) is busy and not being written back this cycle.
- FSM:
  - RUN -> BR_WAIT on accepting a CB or UB instruction.
  - BR_WAIT: instr_ready=0; -> RUN on br_done.
  - br_done while in RUN is ignored.
  - br_done arriving in the acceptance cycle is ignored; the wait begins next cycle.

Decomposition:
- Package rv_isa_pkg holds:
  - opcode[6:2] constants.
  - funct3 constants.
  - JAL/JALR fcs codes (010/011).
  - Enum for RUN/BR_WAIT.
  - Packed struct issue_bundle_t for the flag and operand set.
- One sub-module, rv_imm_gen: purely combinational immediate extraction by opcode.

Test Plan:
- ADDI x1,x0,-5 (0xFFB00093), issue_ready=1 -> next cycle ALU_IMM=1, fcs=000, IOP=0, port2_imm=0xFFFFFFFB, rd_out=1, busy[1] set.
- SUB x3,x1,x2 immediately after a write to x1 pending -> instr_ready=0 until wb_en,wb_addr=1. In the wb cycle the instruction is accepted with port1_reg=wb_data (bypass). Output ALU_REG=1, IOP=1, fcs=000.
- BEQ with pc=0x100, offset +8 -> CB=1, port2_imm=8, program_counter=0x100. instr_ready stays 0 until br_done, then is 1 the following cycle.
- LUI x5,0x12345 -> LUP=1, IOP=1, port2_imm=0x00012345. AUIPC x5,0x12345 -> IOP=0, port2_imm=0x12345000.
- issue_ready=0 for 3 cycles with issue_valid=1 -> bundle unchanged and instr_ready=0. Opcode 1111111 -> illegal_instr pulses once and issue_valid stays 0.
- Assert rst mid-BR_WAIT with busy bits set -> all outputs 0 asynchronously. After release, state=RUN, no stalls, x-registers read 0.
